int_fp_div: RTL and testbench

INT_FP_DIV -- requirements
Module: int_fp_div

---
 rtl/int_fp_div_pkg.sv | 21 ++
 rtl/int_fp_div_step.sv | 23 ++
 rtl/int_fp_div.sv | 186 ++++++++++++++++++
 tb/tb_int_fp_div.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_fp_div_pkg.sv
// Shared types and constants for the int8 / fp16 divider.
package int_fp_div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StDiv,
    StNorm,
    StDone
  } state_e;

  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_MAX = 31;
  localparam int unsigned ITER_INT     = 8;
  localparam int unsigned ITER_FP      = 12;
  localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

  // Partial remainder / divisor width shared by both modes.
  localparam int unsigned DIV_W = 12;

endpackage

// File: rtl/int_fp_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module restoring_div_step #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] divisor,
  input  logic         next_bit,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] trial;

  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // Modular low bits are exact whenever the subtraction is taken.
    trial   = shifted[W-1:0] - divisor;
    rem_out = q_bit ? trial : shifted[W-1:0];
  end

endmodule

// File: rtl/int_fp_div.sv
// Multi-cycle int8 / fp16 divider built around a single reused restoring step.
module int_fp_div
  import int_fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] c,
  output logic [15:0] rem,
  output logic        error,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic signed [6:0] Bias   = 7'(FP16_BIAS);
  localparam logic signed [6:0] ExpMax = 7'(FP16_EXP_MAX);

  state_e state_q, state_d;

  logic              mode_q;
  logic [15:0]       a_q, b_q;
  logic [3:0]        iter_q;
  logic [DIV_W-1:0]  prem_q, dvd_q, dsor_q, quo_q;
  logic              sign_q, zero_a_q, zero_b_q;
  logic signed [6:0] exp_q;
  logic [15:0]       c_q, rem_out_q;
  logic              error_q, out_valid_q;

  logic              accept, last_iter;
  logic [DIV_W-1:0]  step_rem;
  logic              step_q;
  logic [7:0]        mag_a, mag_b;
  logic signed [6:0] exp_setup, exp_f;
  logic [8:0]        q_s, r_s;
  logic [9:0]        mant;
  logic [15:0]       norm_c, norm_rem;
  logic              norm_err;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign last_iter = iter_q == (mode_q ? 4'(ITER_FP - 1) : 4'(ITER_INT - 1));

  assign c         = c_q;
  assign rem       = rem_out_q;
  assign error     = error_q;
  assign out_valid = out_valid_q;

  restoring_div_step #(
    .W(DIV_W)
  ) u_step (
    .rem_in  (prem_q),
    .divisor (dsor_q),
    .next_bit(dvd_q[DIV_W-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StSetup;
      StSetup: state_d = StDiv;
      StDiv:   if (last_iter) state_d = StNorm;
      StNorm:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    mag_a     = a_q[7] ? (~a_q[7:0] + 8'd1) : a_q[7:0];
    mag_b     = b_q[7] ? (~b_q[7:0] + 8'd1) : b_q[7:0];
    exp_setup = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + Bias;
  end

  // Result formatting from the finished quotient/remainder.
  always_comb begin
    norm_c   = '0;
    norm_rem = '0;
    norm_err = 1'b0;
    q_s      = sign_q ? (~{1'b0, quo_q[7:0]} + 9'd1) : {1'b0, quo_q[7:0]};
    r_s      = a_q[7] ? (~{1'b0, prem_q[7:0]} + 9'd1) : {1'b0, prem_q[7:0]};
    mant     = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
    exp_f    = quo_q[11] ? exp_q : exp_q - 7'sd1;
    if (!mode_q) begin
      if (zero_b_q) begin
        norm_err = 1'b1;
      end else begin
        norm_c   = {{7{q_s[8]}}, q_s};
        norm_rem = {{7{r_s[8]}}, r_s};
      end
    end else if (zero_b_q) begin
      norm_c   = {sign_q, FP16_INF_MAG};
      norm_err = 1'b1;
    end else if (zero_a_q) begin
      norm_c   = {sign_q, 15'b0};
    end else if (exp_f >= ExpMax) begin
      norm_c   = {sign_q, FP16_INF_MAG};
      norm_err = 1'b1;
    end else if (exp_f <= 7'sd0) begin
      norm_c   = {sign_q, 15'b0};
      norm_err = 1'b1;
    end else begin
      norm_c   = {sign_q, exp_f[4:0], mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      iter_q      <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      dsor_q      <= '0;
      quo_q       <= '0;
      sign_q      <= 1'b0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      exp_q       <= '0;
      c_q         <= '0;
      rem_out_q   <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            mode_q <= mode;
            a_q    <= a;
            b_q    <= b;
          end
        end
        StSetup: begin
          iter_q <= '0;
          quo_q  <= '0;
          if (mode_q) begin
            // ma >> 1 is always below mb, so the upper quotient bits are known zero.
            prem_q   <= {2'b00, 1'b1, a_q[9:1]};
            dvd_q    <= {a_q[0], 11'b0};
            dsor_q   <= {1'b0, 1'b1, b_q[9:0]};
            sign_q   <= a_q[15] ^ b_q[15];
            zero_a_q <= (a_q[14:0] == 15'd0);
            zero_b_q <= (b_q[14:0] == 15'd0);
            exp_q    <= exp_setup;
          end else begin
            prem_q   <= '0;
            dvd_q    <= {mag_a, 4'b0};
            dsor_q   <= {4'b0, mag_b};
            sign_q   <= a_q[7] ^ b_q[7];
            zero_a_q <= 1'b0;
            zero_b_q <= (b_q[7:0] == 8'd0);
            exp_q    <= '0;
          end
        end
        StDiv: begin
          prem_q <= step_rem;
          dvd_q  <= {dvd_q[DIV_W-2:0], 1'b0};
          quo_q  <= {quo_q[DIV_W-2:0], step_q};
          iter_q <= iter_q + 4'd1;
        end
        StNorm: begin
          c_q         <= norm_c;
          rem_out_q   <= norm_rem;
          error_q     <= norm_err;
          out_valid_q <= 1'b1;
        end
        StDone: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_fp_div.sv
// Self-checking bench: vector table, random int model, stall and reset corners.
module tb_int_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [15:0] c;
  logic [15:0] rem;
  logic        error;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] c;
    logic [15:0] rem;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] rem;
    logic        err;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[15];

  int_fp_div dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .c        (c),
    .rem      (rem),
    .error    (error),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_op(input logic m, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] ec, input logic [15:0] er, input logic ee);
    exp_t e;
    mode     = m;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    e.c      = ec;
    e.rem    = er;
    e.err    = ee;
    e.lat    = m ? 14 : 10;
    sb_q.push_back(e);
  endtask

  // Waits for the accept edge, then for the result, compares and consumes it.
  task automatic finish_op(input string name, input bit consume);
    exp_t e;
    int   lat;
    lat = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hA5A5;
    b        = 16'h0001;
    mode     = ~mode;
    chk({name, " busy"}, {31'd0, in_ready}, 32'd0);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, " latency"}, lat, e.lat);
    chk({name, " c"}, {16'd0, c}, {16'd0, e.c});
    chk({name, " rem"}, {16'd0, rem}, {16'd0, e.rem});
    chk({name, " error"}, {31'd0, error}, {31'd0, e.err});
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, " drop"}, {31'd0, out_valid}, 32'd0);
      chk({name, " ready"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0]       ra, rb;
    logic signed [7:0] s8a, s8b;
    int                qa, ra_i;
    logic [31:0]       qv, rv;
    bit                seen;

    tbl[0]  = '{1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    tbl[1]  = '{1'b0, 16'h00F9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    tbl[2]  = '{1'b0, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    tbl[4]  = '{1'b0, 16'h0080, 16'h0001, 16'hFF80, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 16'h0007, 16'h00FD, 16'hFFFE, 16'h0001, 1'b0};
    tbl[6]  = '{1'b0, 16'h009C, 16'h00F9, 16'h000E, 16'hFFFE, 1'b0};
    tbl[7]  = '{1'b1, 16'h4600, 16'h4000, 16'h4200, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 16'h3C00, 16'h3E00, 16'h3955, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 16'h3C00, 16'h0000, 16'h7C00, 16'h0000, 1'b1};
    tbl[10] = '{1'b1, 16'h8000, 16'h3C00, 16'h8000, 16'h0000, 1'b0};
    tbl[11] = '{1'b1, 16'h7800, 16'h0400, 16'h7C00, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 16'h0400, 16'h7800, 16'h0000, 16'h0000, 1'b1};
    tbl[13] = '{1'b1, 16'h0000, 16'h8000, 16'hFC00, 16'h0000, 1'b1};
    tbl[14] = '{1'b1, 16'hBC00, 16'h4000, 16'hB800, 16'h0000, 1'b0};

    // Reset state.
    #23;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset c", {16'd0, c}, 32'd0);
    chk("reset rem", {16'd0, rem}, 32'd0);
    chk("reset error", {31'd0, error}, 32'd0);

    // First accept on the first edge after reset release.
    @(negedge clk);
    drive_op(tbl[0].mode, tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].rem, tbl[0].err);
    rst_n = 1'b1;
    finish_op("first", 1'b1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].rem, tbl[i].err);
      finish_op($sformatf("vec%0d", i), 1'b1);
    end

    // Random int ops against a behavioural model; upper operand bits are junk.
    for (int i = 0; i < 16; i++) begin
      ra   = 16'($urandom_range(0, 65535));
      rb   = {8'($urandom_range(0, 255)), 8'($urandom_range(1, 255))};
      s8a  = ra[7:0];
      s8b  = rb[7:0];
      qa   = int'(s8a) / int'(s8b);
      ra_i = int'(s8a) % int'(s8b);
      qv   = qa;
      rv   = ra_i;
      @(negedge clk);
      drive_op(1'b0, ra, rb, qv[15:0], rv[15:0], 1'b0);
      finish_op($sformatf("rand%0d", i), 1'b1);
    end

    // Back-pressure: result must hold while out_ready is low; new requests ignored.
    @(negedge clk);
    drive_op(1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0);
    finish_op("stall", 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a        = 16'h0010;
      b        = 16'h0001;
      @(posedge clk);
      #1;
      chk("stall out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall c", {16'd0, c}, 32'h000E);
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall drop", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("stall no phantom", {31'd0, seen}, 32'd0);

    // Reset pulsed mid-division: abandoned op never reports.
    @(negedge clk);
    mode     = 1'b0;
    a        = 16'h0064;
    b        = 16'h0007;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst c async", {16'd0, c}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst no result", {31'd0, seen}, 32'd0);
    @(negedge clk);
    drive_op(1'b1, 16'h3C00, 16'h3E00, 16'h3955, 16'h0000, 1'b0);
    rst_n = 1'b1;
    finish_op("after rst", 1'b1);

    chk("scoreboard empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
